// File: rtl/servo_pkg.sv
// Shared definitions for the servo command link: ASCII framing bytes,
// error encodings, parser states and command field widths.
package servo_pkg;

  localparam logic [7:0] SOF     = 8'h23;  // '#'
  localparam logic [7:0] SEP_P   = 8'h50;  // 'P'
  localparam logic [7:0] SEP_T   = 8'h54;  // 'T'
  localparam logic [7:0] EOF     = 8'h21;  // '!'
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  localparam int ID_W     = 8;
  localparam int PWM_W    = 12;
  localparam int TIME_W   = 14;
  localparam int ACC_W    = 14;
  localparam int ID_ACC_W = 10;  // three decimal digits, up to 999

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SYNTAX  = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    S_HUNT,
    S_ID,
    S_P_SEP,
    S_PWM,
    S_T_SEP,
    S_TIME,
    S_END
  } parser_state_e;

endpackage

// File: rtl/ascii_digit_acc.sv
// Decimal accumulator fed with ASCII digits: flags digit bytes, computes
// acc*10 + digit, and updates on shift or clears to zero on clear.
module ascii_digit_acc
  import servo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data,
  input  logic             clear,
  input  logic             shift,
  output logic             is_digit,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_next
);

  assign is_digit = (data >= ASCII_0) && (data <= ASCII_9);

  // For a digit byte the low nibble equals byte - '0'.
  assign acc_next = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, data[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (shift) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/servo_cmd_parser.sv
// Parses '#iiiPppppTtttt!' byte frames into id/pwm/time commands; bad,
// out-of-range or stalled frames are dropped with a one-cycle error strobe.
module servo_cmd_parser
  import servo_pkg::*;
#(
  parameter int unsigned MAX_ID         = 5,
  parameter int unsigned PWM_MIN        = 500,
  parameter int unsigned PWM_MAX        = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ID_W-1:0]   cmd_id,
  output logic [PWM_W-1:0]  cmd_pwm,
  output logic [TIME_W-1:0] cmd_time,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_ACC_W-1:0] MAX_ID_L  = ID_ACC_W'(MAX_ID);
  localparam logic [ACC_W-1:0]    PWM_MIN_L = ACC_W'(PWM_MIN);
  localparam logic [ACC_W-1:0]    PWM_MAX_L = ACC_W'(PWM_MAX);

  parser_state_e        state, state_d;
  logic [1:0]           dcnt, dcnt_d;
  logic [GAP_W-1:0]     gap;
  logic [ID_ACC_W-1:0]  id_q;
  logic [ACC_W-1:0]     pwm_q;
  logic [ACC_W-1:0]     acc, acc_next;
  logic                 accept, is_digit, gap_run, timeout, range_bad;
  logic                 acc_clear, acc_shift, latch_id, latch_pwm, emit, err_set;
  err_code_e            err_d;

  assign in_ready  = !cmd_valid;
  assign accept    = in_valid && in_ready;
  assign gap_run   = (state != S_HUNT) && !cmd_valid;
  assign timeout   = gap_run && !accept && (gap == GAP_LAST);
  assign range_bad = (id_q > MAX_ID_L) || (pwm_q < PWM_MIN_L) || (pwm_q > PWM_MAX_L);

  ascii_digit_acc u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (in_data),
    .clear    (acc_clear),
    .shift    (acc_shift),
    .is_digit (is_digit),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_HUNT;
      dcnt  <= '0;
    end else begin
      state <= state_d;
      dcnt  <= dcnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    dcnt_d    = dcnt;
    acc_clear = 1'b0;
    acc_shift = 1'b0;
    latch_id  = 1'b0;
    latch_pwm = 1'b0;
    emit      = 1'b0;
    err_set   = 1'b0;
    err_d     = ERR_NONE;

    if (accept) begin
      if (in_data == SOF) begin
        // Start-of-frame always resynchronises; only mid-frame is it an error.
        if (state != S_HUNT) begin
          err_set = 1'b1;
          err_d   = ERR_SYNTAX;
        end
        state_d   = S_ID;
        dcnt_d    = '0;
        acc_clear = 1'b1;
      end else begin
        case (state)
          S_HUNT: ;
          S_ID, S_PWM, S_TIME: begin
            if (is_digit) begin
              acc_shift = 1'b1;
              if (dcnt == ((state == S_ID) ? 2'd2 : 2'd3)) begin
                dcnt_d = '0;
                case (state)
                  S_ID:    begin latch_id  = 1'b1; state_d = S_P_SEP; end
                  S_PWM:   begin latch_pwm = 1'b1; state_d = S_T_SEP; end
                  default: state_d = S_END;
                endcase
              end else begin
                dcnt_d = dcnt + 2'd1;
              end
            end else begin
              err_set = 1'b1;
              err_d   = ERR_SYNTAX;
              state_d = S_HUNT;
              dcnt_d  = '0;
            end
          end
          S_P_SEP, S_T_SEP: begin
            if (in_data == ((state == S_P_SEP) ? SEP_P : SEP_T)) begin
              state_d   = (state == S_P_SEP) ? S_PWM : S_TIME;
              acc_clear = 1'b1;
            end else begin
              err_set = 1'b1;
              err_d   = ERR_SYNTAX;
              state_d = S_HUNT;
            end
          end
          S_END: begin
            state_d = S_HUNT;
            if (in_data != EOF) begin
              err_set = 1'b1;
              err_d   = ERR_SYNTAX;
            end else if (range_bad) begin
              err_set = 1'b1;
              err_d   = ERR_RANGE;
            end else begin
              emit = 1'b1;
            end
          end
          default: state_d = S_HUNT;
        endcase
      end
    end else if (timeout) begin
      err_set = 1'b1;
      err_d   = ERR_TIMEOUT;
      state_d = S_HUNT;
      dcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap       <= '0;
      id_q      <= '0;
      pwm_q     <= '0;
      cmd_id    <= '0;
      cmd_pwm   <= '0;
      cmd_time  <= '0;
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      if (accept || !gap_run || timeout) begin
        gap <= '0;
      end else begin
        gap <= gap + 1'b1;
      end
      if (latch_id) begin
        id_q <= acc_next[ID_ACC_W-1:0];
      end
      if (latch_pwm) begin
        pwm_q <= acc_next;
      end
      // Time is complete in the accumulator by the time '!' arrives.
      if (emit) begin
        cmd_valid <= 1'b1;
        cmd_id    <= id_q[ID_W-1:0];
        cmd_pwm   <= pwm_q[PWM_W-1:0];
        cmd_time  <= acc;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      err_valid <= err_set;
      err_code  <= err_d;
    end
  end

endmodule

// File: doc/servo_cmd_parser.md
# servo_cmd_parser

Receive-side decoder for the servo command protocol: consumes the byte stream delivered by `uart_rx` (valid/ready) and parses frames of the form `#iiiPppppTtttt!` (for example `#001P0600T2000!`) into a servo id, a pulse width and a move time. It sits between `uart_rx` and the servo PWM/motion logic, on the servo-controller side of the link. Malformed, out-of-range and stalled frames are discarded and reported on an error strobe.

## Interface
- `MAX_ID`, default 5: highest accepted servo id.
- `PWM_MIN`, default 500: lowest accepted pulse width (µs).
- `PWM_MAX`, default 2500: highest accepted pulse width (µs).
- `TIMEOUT_CYCLES`, default 100_000: maximum gap between bytes inside a frame (2 ms at 50 MHz).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 8: received byte.
- `in_valid` in 1: byte available.
- `in_ready` out 1: parser accepts byte.
- `cmd_id` out 8: parsed servo id.
- `cmd_pwm` out 12: parsed pulse width.
- `cmd_time` out 14: parsed move time, 0–9999 ms.
- `cmd_valid` out 1: command available, held until accepted.
- `cmd_ready` in 1: consumer takes command.
- `err_valid` out 1: one-cycle error strobe.
- `err_code` out 2: 1 = syntax, 2 = range, 3 = timeout; valid with `err_valid`.

## Operation
- A byte is accepted on a cycle with `in_valid && in_ready`. `in_ready` = `!cmd_valid`: while a command is pending, input is back-pressured.
- States:
  - `HUNT`: discard everything except `#`; `#` → `ID`.
  - `ID`: 3 digits → `P_SEP`.
  - `P_SEP`: `P` → `PWM`.
  - `PWM`: 4 digits → `T_SEP`.
  - `T_SEP`: `T` → `TIME`.
  - `TIME`: 4 digits → `END`.
  - `END`: `!` → `HUNT` and emit the command.
- A digit counter (2 bits) counts digits inside `ID`/`PWM`/`TIME`.
- Digit arithmetic: `acc <= acc*10 + (byte - 8'h30)`. Accumulator is 14 bits wide (max 9999, no overflow possible). The accumulator clears on entering each numeric field.
- A `#` in any non-`HUNT` state aborts the current frame, raises a syntax error, and restarts at `ID` (resync). In `HUNT`, `#` is never an error.
- Any other unexpected byte outside `HUNT` (non-digit in a digit field, wrong separator, wrong terminator) raises a syntax error and returns to `HUNT`.
- Range check on `!`: if id > `MAX_ID`, or pwm < `PWM_MIN`, or pwm > `PWM_MAX`, raise a range error, emit no command, and go to `HUNT`. Time is never range-checked.
- Valid frame: latch `cmd_id` (low 8 bits of the id accumulator), `cmd_pwm` and `cmd_time`; set `cmd_valid`. It clears on the cycle `cmd_valid && cmd_ready`.
- Timeout: a gap counter resets on each accepted byte and counts only when state ≠ `HUNT` and `cmd_valid` = 0. Reaching `TIMEOUT_CYCLES` raises a timeout error and returns to `HUNT`.

## Timing
- Reset values: `in_ready` = 1, `cmd_valid` = 0, `err_valid` = 0, `err_code` = 0, `cmd_id`/`cmd_pwm`/`cmd_time` = 0. State `HUNT`, counters 0.
- Reset mid-frame drops the partial frame and any pending command.
- `cmd_valid` rises 1 cycle after the clock edge that accepts `!`. `err_valid` pulses 1 cycle after the offending byte or the timeout count.
- `cmd_*` values are stable while `cmd_valid` = 1.
- One byte per cycle is accepted; back-to-back bytes are supported, so a 15-byte frame can complete in 15 cycles.
- If `cmd_ready` is asserted on the same cycle `cmd_valid` rises, the handshake completes that cycle. `in_ready` returns to 1 the following cycle.
- Error and command are never flagged for the same frame. Only one error is raised per aborted frame.

## Structure
- A shared package `servo_pkg` holds:
  - the ASCII constants `SOF` = `#`, `SEP_P` = `P`, `SEP_T` = `T`, `EOF` = `!`;
  - the `err_code` encodings;
  - the parser state enumeration;
  - the 8/12/14-bit field widths, also used by the `servo_control` command generator.
- A single sub-module `ascii_digit_acc` contains the digit check, the ×10 accumulate and the clear.
- All other logic is in one FSM plus the timeout counter.

## Test plan
- Feed `#001P0600T2000!` back-to-back with `cmd_ready` = 1 → one `cmd_valid` pulse with id = 1, pwm = 600, time = 2000, and no error.
- Hold `cmd_ready` = 0 after a valid frame, then stream a second frame → `in_ready` = 0, bytes are not consumed, and the first command holds. Release `cmd_ready` → the second command (`#000P0500T1000!`: 0/500/1000) follows.
- Send `#00A...` → syntax error (code 1) at `A`, returns to `HUNT`. Then `##001P1500T0000!` → a single syntax error at the second `#`, then command 1/1500/0.
- Send `#009P0600T2000!` and `#001P2600T2000!` → two range errors (code 2), and no `cmd_valid`.
- Send `#001P06`, then stay idle for `TIMEOUT_CYCLES` → timeout error (code 3) exactly at the count. A subsequent valid frame decodes correctly.
- Assert reset after `#001P` → outputs return to reset values. A following full frame decodes correctly.
